// File: rtl/multicore_debug_halt_sequencer_if.sv
// Debug-control bundle between the halt sequencer, the per-core debug modules and the host register.
// The sequencer is the slave side. The master side drives the core status and the host commands.
interface multicore_debug_halt_sequencer_if #(
  parameter int NUM_CORES = 7
);
  localparam int FCW = $clog2(NUM_CORES + 1);

  logic [NUM_CORES-1:0] debugack;
  logic [NUM_CORES-1:0] halt_mask;
  logic                 host_halt_req;
  logic                 host_resume_req;
  logic [NUM_CORES-1:0] debugreq;
  logic [NUM_CORES-1:0] resumereq;
  logic [1:0]           state;
  logic                 halted_all;
  logic [FCW-1:0]       first_core;
  logic                 timeout_err;

  modport master (
    output debugack, halt_mask, host_halt_req, host_resume_req,
    input  debugreq, resumereq, state, halted_all, first_core, timeout_err
  );

  modport slave (
    input  debugack, halt_mask, host_halt_req, host_resume_req,
    output debugreq, resumereq, state, halted_all, first_core, timeout_err
  );
endinterface

// File: rtl/multicore_debug_halt_sequencer.sv
// Group debug halt/resume sequencer for NUM_CORES Nios II cores.
// Optional macro MULTICORE_DEBUG_SYNC_DEBUGACK_EN adds a 2-flop synchronizer on every debugack bit.
module multicore_debug_halt_sequencer #(
  parameter int NUM_CORES      = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset_n,
  multicore_debug_halt_sequencer_if.slave   dbg
);
  localparam int FCW = $clog2(NUM_CORES + 1);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_HALTING  = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;
  localparam logic [1:0] ST_RESUMING = 2'd3;

  logic [NUM_CORES-1:0] ack;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] rise;
  logic [FCW-1:0]       rise_idx;
  logic                 timeout_hit;

  logic [1:0]           state_q,       state_d;
  logic [NUM_CORES-1:0] debugreq_q,    debugreq_d;
  logic [NUM_CORES-1:0] resumereq_q,   resumereq_d;
  logic                 halted_all_q,  halted_all_d;
  logic [FCW-1:0]       first_core_q,  first_core_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CW-1:0]        cnt_q,         cnt_d;
  logic [NUM_CORES-1:0] ack_prev_q;

`ifdef MULTICORE_DEBUG_SYNC_DEBUGACK_EN
  logic [NUM_CORES-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dbg.debugack;
      sync2_q <= sync1_q;
    end
  end

  assign ack = sync2_q;
`else
  assign ack = dbg.debugack;
`endif

  assign mask        = dbg.halt_mask;
  assign rise        = ack & ~ack_prev_q & mask;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Scan from the top so the lowest rising core is the one that sticks.
  always_comb begin
    rise_idx = FCW'(NUM_CORES);
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = FCW'(i);
    end
  end

  // NOTE: every _d is defaulted to its _q first, so no path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    debugreq_d    = debugreq_q;
    resumereq_d   = resumereq_q;
    halted_all_d  = halted_all_q;
    first_core_d  = first_core_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_RUN: begin
        debugreq_d  = '0;
        resumereq_d = '0;
        if (dbg.host_halt_req || (rise != '0)) begin
          state_d       = ST_HALTING;
          cnt_d         = '0;
          timeout_err_d = 1'b0;
          halted_all_d  = 1'b0;
          first_core_d  = rise_idx;
        end
      end
      ST_HALTING: begin
        cnt_d = cnt_q + 1'b1;
        if ((ack & mask) == mask) begin
          state_d      = ST_HALTED;
          halted_all_d = 1'b1;
          debugreq_d   = '0;
        end else if (timeout_hit) begin
          state_d       = ST_HALTED;
          halted_all_d  = 1'b0;
          timeout_err_d = 1'b1;
          debugreq_d    = '0;
        end else begin
          debugreq_d = mask & ~ack;
        end
      end
      ST_HALTED: begin
        debugreq_d = '0;
        if (dbg.host_resume_req) begin
          state_d      = ST_RESUMING;
          cnt_d        = '0;
          halted_all_d = 1'b0;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if ((ack & mask) == '0) begin
          state_d     = ST_RUN;
          resumereq_d = '0;
        end else if (timeout_hit) begin
          state_d       = ST_RUN;
          timeout_err_d = 1'b1;
          resumereq_d   = '0;
        end else begin
          resumereq_d = mask & ack;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      debugreq_q    <= '0;
      resumereq_q   <= '0;
      halted_all_q  <= 1'b0;
      first_core_q  <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      ack_prev_q    <= '0;
    end else begin
      state_q       <= state_d;
      debugreq_q    <= debugreq_d;
      resumereq_q   <= resumereq_d;
      halted_all_q  <= halted_all_d;
      first_core_q  <= first_core_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      ack_prev_q    <= ack;
    end
  end

  assign dbg.state       = state_q;
  assign dbg.debugreq    = debugreq_q;
  assign dbg.resumereq   = resumereq_q;
  assign dbg.halted_all  = halted_all_q;
  assign dbg.first_core  = first_core_q;
  assign dbg.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_multicore_debug_halt_sequencer.sv
// Self-checking bench for multicore_debug_halt_sequencer: directed scenarios plus randomized
// core/host traffic, compared every cycle against a behavioural model of the halt protocol.
module tb_multicore_debug_halt_sequencer;
  localparam int NC  = 7;
  localparam int TMO = 255;

  typedef enum int {S_RUN = 0, S_HALTING = 1, S_HALTED = 2, S_RESUMING = 3} phase_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  multicore_debug_halt_sequencer_if #(.NUM_CORES(NC)) dbg_if ();

  multicore_debug_halt_sequencer #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dbg     (dbg_if)
  );

  always #5 clk = ~clk;

  // Reference model of the protocol.
  phase_t      m_state;
  logic [6:0]  m_dreq, m_rreq, m_prev, m_s1, m_s2;
  logic        m_hall, m_tout;
  int          m_first, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = S_RUN; m_dreq = '0; m_rreq = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    m_hall = 1'b0; m_tout = 1'b0; m_first = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_step();
    logic [6:0] a, m, rise;
    int old_cnt;
`ifdef MULTICORE_DEBUG_SYNC_DEBUGACK_EN
    a = m_s2; m_s2 = m_s1; m_s1 = dbg_if.debugack;
`else
    a = dbg_if.debugack;
`endif
    m = dbg_if.halt_mask;
    rise = a & ~m_prev & m;
    m_prev = a;
    old_cnt = m_cnt;
    case (m_state)
      S_RUN: begin
        m_dreq = '0; m_rreq = '0;
        if (dbg_if.host_halt_req || rise != 0) begin
          m_state = S_HALTING; m_cnt = 0; m_tout = 1'b0; m_hall = 1'b0;
          m_first = NC;
          for (int i = 0; i < NC; i++) if (rise[i]) begin m_first = i; break; end
        end
      end
      S_HALTING: begin
        m_cnt = old_cnt + 1;
        if ((a & m) == m) begin m_state = S_HALTED; m_hall = 1'b1; m_dreq = '0; end
        else if (old_cnt == TMO - 1) begin m_state = S_HALTED; m_hall = 1'b0; m_tout = 1'b1; m_dreq = '0; end
        else m_dreq = m & ~a;
      end
      S_HALTED: begin
        m_dreq = '0;
        if (dbg_if.host_resume_req) begin m_state = S_RESUMING; m_cnt = 0; m_hall = 1'b0; end
      end
      S_RESUMING: begin
        m_cnt = old_cnt + 1;
        if ((a & m) == 0) begin m_state = S_RUN; m_rreq = '0; end
        else if (old_cnt == TMO - 1) begin m_state = S_RUN; m_tout = 1'b1; m_rreq = '0; end
        else m_rreq = m & a;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("state",       32'(dbg_if.state),       32'(m_state));
    check("debugreq",    32'(dbg_if.debugreq),    32'(m_dreq));
    check("resumereq",   32'(dbg_if.resumereq),   32'(m_rreq));
    check("halted_all",  32'(dbg_if.halted_all),  32'(m_hall));
    check("first_core",  32'(dbg_if.first_core),  32'(m_first));
    check("timeout_err", 32'(dbg_if.timeout_err), 32'(m_tout));
  endtask

  // One clock: model steps on the applied inputs, DUT is sampled 1 time unit after the edge,
  // then the single-cycle host commands are withdrawn.
  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    compare_all();
    dbg_if.host_halt_req   = 1'b0;
    dbg_if.host_resume_req = 1'b0;
  endtask

  task automatic wait_state(input int target, input int budget, input string tag, output int used);
    used = 0;
    while (dbg_if.state != 2'(target) && used < budget) begin
      cyc();
      used++;
    end
    check(tag, 32'(dbg_if.state == 2'(target)), 32'd1);
  endtask

  // Resume from HALTED and let every core leave debug mode.
  task automatic resume_all();
    int used;
    dbg_if.host_resume_req = 1'b1;
    cyc();
    dbg_if.debugack = '0;
    wait_state(S_RUN, 20, "resume_reaches_run", used);
  endtask

  initial begin
    int used;
    dbg_if.debugack        = '0;
    dbg_if.halt_mask       = 7'h7F;
    dbg_if.host_halt_req   = 1'b0;
    dbg_if.host_resume_req = 1'b0;
    reset_n = 1'b0;
    m_reset();
    #12;
    compare_all();
    reset_n = 1'b1;

    // Host halt, all cores ack 3 cycles after debugreq appears.
    dbg_if.host_halt_req = 1'b1;
    cyc();
    cyc();
    check("host_halt_debugreq", 32'(dbg_if.debugreq), 32'h7F);
    cyc(); cyc(); cyc();
    dbg_if.debugack = 7'h7F;
    cyc();
    check("host_halt_state", 32'(dbg_if.state), 32'(S_HALTED));
    check("host_halt_first", 32'(dbg_if.first_core), 32'd7);
    check("host_halt_all",   32'(dbg_if.halted_all), 32'd1);

    // Resume with acks dropping one per cycle.
    dbg_if.host_resume_req = 1'b1;
    cyc();
    cyc();
    check("resumereq_all", 32'(dbg_if.resumereq), 32'h7F);
    for (int i = 0; i < NC; i++) begin
      dbg_if.debugack[i] = 1'b0;
      cyc();
    end
    check("resume_run",     32'(dbg_if.state),     32'(S_RUN));
    check("resume_rreq_0",  32'(dbg_if.resumereq), 32'd0);

    // Core 3 enters debug on its own.
    dbg_if.debugack = 7'h08;
    cyc();
    check("core3_first", 32'(dbg_if.first_core), 32'd3);
    cyc();
    check("core3_debugreq", 32'(dbg_if.debugreq), 32'h77);
    for (int i = 0; i < NC; i++) begin
      dbg_if.debugack[i] = 1'b1;
      cyc();
    end
    check("core3_halted", 32'(dbg_if.state), 32'(S_HALTED));
    resume_all();

    // Core 5 never acks: timeout after exactly TMO HALTING cycles.
    dbg_if.host_halt_req = 1'b1;
    cyc();
    dbg_if.debugack = 7'h5F;
    wait_state(S_HALTED, 300, "timeout_reaches_halted", used);
    check("timeout_cycles", 32'(used), 32'(TMO));
    check("timeout_err_set", 32'(dbg_if.timeout_err), 32'd1);
    check("timeout_hall_0",  32'(dbg_if.halted_all),  32'd0);
    resume_all();
    dbg_if.host_halt_req = 1'b1;
    cyc();
    check("timeout_err_cleared", 32'(dbg_if.timeout_err), 32'd0);
    dbg_if.debugack = 7'h7F;
    wait_state(S_HALTED, 10, "post_timeout_halt", used);
    resume_all();

    // Cores 1 and 4 rise together with a host request: the core wins.
    dbg_if.debugack = 7'h12;
    dbg_if.host_halt_req = 1'b1;
    cyc();
    check("coincident_first", 32'(dbg_if.first_core), 32'd1);
    dbg_if.debugack = 7'h7F;
    wait_state(S_HALTED, 10, "coincident_halted", used);
    resume_all();
    dbg_if.host_resume_req = 1'b1;
    cyc();
    check("resume_in_run_ignored", 32'(dbg_if.state), 32'(S_RUN));

    // Asynchronous reset in HALTING with debugreq = 3C.
    dbg_if.debugack = 7'h43;
    cyc();
    cyc();
    check("pre_reset_debugreq", 32'(dbg_if.debugreq), 32'h3C);
    #3 reset_n = 1'b0;
    #1;
    m_reset();
    check("async_reset_debugreq", 32'(dbg_if.debugreq), 32'd0);
    compare_all();
    dbg_if.debugack = '0;
    #2 reset_n = 1'b1;

    // Empty mask completes on the first HALTING cycle.
    dbg_if.halt_mask = '0;
    dbg_if.host_halt_req = 1'b1;
    cyc();
    cyc();
    check("empty_mask_halted", 32'(dbg_if.state), 32'(S_HALTED));
    check("empty_mask_hall",   32'(dbg_if.halted_all), 32'd1);
    resume_all();
    dbg_if.halt_mask = 7'h7F;

    // Randomized traffic: cores answer debugreq/resumereq with random delay.
    for (int n = 0; n < 2500; n++) begin
      logic [6:0] a;
      a = dbg_if.debugack;
      for (int i = 0; i < NC; i++) begin
        if (dbg_if.debugreq[i] && !a[i] && ($urandom % 3 == 0)) a[i] = 1'b1;
        else if (dbg_if.resumereq[i] && a[i] && ($urandom % 3 == 0)) a[i] = 1'b0;
        else if (dbg_if.state == 2'(S_RUN) && !a[i] && ($urandom % 60 == 0)) a[i] = 1'b1;
        else if (dbg_if.state == 2'(S_RUN) && a[i] && ($urandom % 4 == 0)) a[i] = 1'b0;
      end
      dbg_if.debugack = a;
      if ($urandom % 50 == 0) dbg_if.halt_mask = 7'($urandom);
      dbg_if.host_halt_req   = ($urandom % 10 == 0);
      dbg_if.host_resume_req = ($urandom % 6 == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/multicore_debug_halt_sequencer.md
Name: multicore_debug_halt_sequencer

Overview:
- Coordinates debug halt and resume across the NUM_CORES Nios II cores of the multicore platform.
- A halt starts in one of two ways: the host requests it, or any participating core enters debug mode (debugack rises).
- The block then drives debugreq to every other participating core until all have halted.
- On a host resume command, it releases all participating cores and waits until each has left debug mode.
- Sits in the system-clock domain, between the per-core debug modules and the host debug control register.

Parameters:
- NUM_CORES, 7, number of cores sequenced.
- TIMEOUT_CYCLES, 255, maximum clk cycles spent in HALTING or RESUMING before aborting; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- debugack  input  NUM_CORES  per-core "in debug mode" status.
- halt_mask  input  NUM_CORES  1 = core participates in group halt; sampled every cycle.
- host_halt_req  input  1  single-cycle halt command.
- host_resume_req  input  1  single-cycle resume command.
- debugreq  output  NUM_CORES  per-core halt request, level.
- resumereq  output  NUM_CORES  per-core resume request, level.
- state  output  2  0=RUN, 1=HALTING, 2=HALTED, 3=RESUMING.
- halted_all  output  1  all masked cores acknowledged halt.
- first_core  output  $clog2(NUM_CORES+1)  initiator of the last halt; value NUM_CORES = host.
- timeout_err  output  1  sticky; last HALTING or RESUMING phase timed out.

Behaviour:
- Interface: one clock clk; reset_n asynchronous, active-low. All outputs registered.
- Reset values: state=RUN, debugreq=0, resumereq=0, halted_all=0, first_core=0, timeout_err=0, counter=0, ack_prev=0.
- Definitions:
  - ack = debugack (or its synchronized version, see Optional Feature).
  - m = halt_mask.
  - rise = ack & ~ack_prev & m; ack_prev is registered every cycle in every state.
- RUN:
  - debugreq=0, resumereq=0.
  - If host_halt_req=1 or rise!=0, go to HALTING next cycle, clear counter, clear timeout_err, halted_all=0.
  - first_core = lowest set index of rise; if rise=0 (host-only request), first_core = NUM_CORES. If host request and core edge coincide, the core index wins.
  - host_resume_req in RUN is ignored.
- HALTING:
  - debugreq = m & ~ack, registered; it updates one cycle after ack.
  - Counter increments once per cycle.
  - If (ack & m)==m, go to HALTED and set halted_all=1.
  - Otherwise, if counter==TIMEOUT_CYCLES-1, go to HALTED with halted_all=0 and timeout_err=1.
  - Completion has priority over timeout in the same cycle.
  - host_halt_req and host_resume_req are ignored.
  - m==0 completes on the first HALTING cycle, with halted_all=1.
- HALTED:
  - debugreq=0.
  - halted_all is held.
  - host_resume_req=1 moves to RESUMING next cycle, with counter cleared and halted_all=0.
  - host_halt_req is ignored.
- RESUMING:
  - resumereq = m & ack, registered.
  - Counter increments once per cycle.
  - When (ack & m)==0, go to RUN with resumereq=0.
  - On reaching TIMEOUT_CYCLES-1, go to RUN with timeout_err=1 and resumereq=0.
  - Completion has priority over timeout.
  - Cores are not re-halted by their own ack edges here; edge detection applies only in RUN.
- halt_mask changes mid-phase take effect on the next cycle's completion check.
- reset_n assertion in any state immediately (asynchronously) forces all reset values; in-flight debugreq/resumereq drop at once.
- timeout_err stays set until the next entry into HALTING.
- Latency:
  - Core edge to debugreq on other cores: 2 cycles (edge registered, then RUN→HALTING).
  - host_halt_req to debugreq: 2 cycles.

Optional Feature:
- Macro: MULTICORE_DEBUG_SYNC_DEBUGACK_EN.
- Defined: each debugack bit passes through a 2-flop synchronizer (reset to 0) before use as ack. All ack-dependent latencies grow by 2 cycles.
- Undefined: ack = debugack directly; debugack must already be synchronous to clk.

Test Plan:
- Host halt, m=7'h7F, all cores ack 3 cycles after debugreq → debugreq=7'h7F, then state=HALTED, halted_all=1, first_core=7, timeout_err=0.
- Core 3 raises debugack in RUN, m=7'h7F → first_core=3, debugreq=7'h77 within 2 cycles; each bit drops as the matching ack rises; HALTED reached.
- Core 5 never acks, m=7'h7F, TIMEOUT_CYCLES=255 → HALTED exactly 255 cycles after entering HALTING, halted_all=0, timeout_err=1; the next halt clears timeout_err.
- From HALTED with all ack=1, host_resume_req → resumereq=7'h7F; acks drop one per cycle → RUN when the last drops, resumereq=0.
- Cores 1 and 4 rise in the same cycle as host_halt_req → first_core=1; host_resume_req in RUN → no state change.
- reset_n pulled low in HALTING with debugreq=7'h3C → debugreq=0 and state=RUN with no clk edge; m=0 host halt → HALTED after 1 HALTING cycle, halted_all=1.
